// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its helpers.
package stopwatch_pkg;

    // Width of the elapsed tick counter (holds 59:59.999 at 10 ns per tick).
    localparam int TICK_W = 39;

    // Width of the lap counter.
    localparam int LAP_W = 4;

    // Default saturation count: 59:59.999 expressed in 10 ns ticks.
    localparam logic [TICK_W-1:0] SW_MAX_TICKS = 39'd359_999_999_999;

    // Controller states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_LAP    = 2'd3
    } sw_state_e;

endpackage

// File: rtl/stopwatch_edge_detect.sv
// One-bit rising-edge detector for a debounced button level.
// The history flop resets to 1 so a button held through reset gives no edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    // Next history value is simply the current sample.
    always_comb begin
        prev_d = din;
    end

    // History register, forced high during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch control: start/stop/lap/clear FSM, saturating elapsed counter,
// lap capture and registered display value for the time-to-BCD converter.
// Button edges: clear beats start_stop beats lap; losers in a cycle are dropped.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter logic [TICK_W-1:0] MAX_TICKS = SW_MAX_TICKS,
    parameter logic [LAP_W-1:0]  LAP_MAX   = 4'd15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start_stop,
    input  logic              btn_lap,
    input  logic              btn_clear,
    output logic [TICK_W-1:0] time_out,
    output logic              running,
    output logic              lap_hold,
    output logic [LAP_W-1:0]  lap_count,
    output logic              overflow,
    output logic [1:0]        state_dbg
);

    logic ss_edge;
    logic lap_edge;
    logic clr_edge;

    edge_detect u_ed_ss  (.clk(clk), .rst(rst), .din(btn_start_stop), .rise(ss_edge));
    edge_detect u_ed_lap (.clk(clk), .rst(rst), .din(btn_lap),        .rise(lap_edge));
    edge_detect u_ed_clr (.clk(clk), .rst(rst), .din(btn_clear),      .rise(clr_edge));

    sw_state_e         state_q, state_d;
    logic [TICK_W-1:0] count_q, count_d;
    logic [TICK_W-1:0] lap_q, lap_d;
    logic [TICK_W-1:0] time_out_q, time_out_d;
    logic [LAP_W-1:0]  lap_count_q, lap_count_d;
    logic              overflow_q, overflow_d;
    logic              running_q, running_d;
    logic              lap_hold_q, lap_hold_d;
    logic              advancing;
    logic              saturate;

    // Next-state, counter, lap capture and display values.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        lap_d       = lap_q;
        lap_count_d = lap_count_q;
        overflow_d  = overflow_q;
        advancing   = (state_q == ST_RUN) || (state_q == ST_LAP);
        saturate    = advancing && (count_q >= MAX_TICKS);

        // Counter advances in RUN and LAP; at the limit it parks in PAUSED.
        if (advancing) begin
            if (saturate) begin
                count_d    = MAX_TICKS;
                overflow_d = 1'b1;
                state_d    = ST_PAUSED;
            end else begin
                count_d = count_q + TICK_W'(1);
            end
        end

        if (clr_edge) begin
            state_d     = ST_IDLE;
            count_d     = '0;
            lap_d       = '0;
            lap_count_d = '0;
            overflow_d  = 1'b0;
        end else if (!saturate) begin
            if (ss_edge) begin
                case (state_q)
                    ST_IDLE:   state_d = ST_RUN;
                    ST_RUN:    state_d = ST_PAUSED;
                    ST_PAUSED: if (!overflow_q) state_d = ST_RUN;
                    ST_LAP:    state_d = ST_PAUSED;
                    default:   state_d = ST_IDLE;
                endcase
            end else if (lap_edge) begin
                case (state_q)
                    ST_RUN: begin
                        lap_d   = count_q;
                        state_d = ST_LAP;
                        if (lap_count_q != LAP_MAX) begin
                            lap_count_d = lap_count_q + LAP_W'(1);
                        end
                    end
                    ST_LAP:  state_d = ST_RUN;
                    default: state_d = state_q;
                endcase
            end
        end

        // Display and status follow the current state, one clock later.
        time_out_d = (state_q == ST_LAP) ? lap_q : count_q;
        running_d  = advancing;
        lap_hold_d = (state_q == ST_LAP);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            lap_q       <= '0;
            time_out_q  <= '0;
            lap_count_q <= '0;
            overflow_q  <= 1'b0;
            running_q   <= 1'b0;
            lap_hold_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            lap_q       <= lap_d;
            time_out_q  <= time_out_d;
            lap_count_q <= lap_count_d;
            overflow_q  <= overflow_d;
            running_q   <= running_d;
            lap_hold_q  <= lap_hold_d;
        end
    end

    assign time_out  = time_out_q;
    assign running   = running_q;
    assign lap_hold  = lap_hold_q;
    assign lap_count = lap_count_q;
    assign overflow  = overflow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: a default instance and one with a
// tiny saturation limit share the same clock, reset and buttons.
module tb_stopwatch_controller;
    import stopwatch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_ss = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clr = 1'b0;

    logic [38:0] a_time, b_time;
    logic        a_run, b_run;
    logic        a_hold, b_hold;
    logic [3:0]  a_laps, b_laps;
    logic        a_ovf, b_ovf;
    logic [1:0]  a_st, b_st;

    int vectors = 0;
    int miscompares = 0;

    // clock / reset
    always #5 clk = ~clk;

    stopwatch_controller dut_a (
        .clk(clk), .rst(rst), .btn_start_stop(btn_ss), .btn_lap(btn_lap),
        .btn_clear(btn_clr), .time_out(a_time), .running(a_run),
        .lap_hold(a_hold), .lap_count(a_laps), .overflow(a_ovf), .state_dbg(a_st)
    );

    stopwatch_controller #(.MAX_TICKS(39'd100)) dut_b (
        .clk(clk), .rst(rst), .btn_start_stop(btn_ss), .btn_lap(btn_lap),
        .btn_clear(btn_clr), .time_out(b_time), .running(b_run),
        .lap_hold(b_hold), .lap_count(b_laps), .overflow(b_ovf), .state_dbg(b_st)
    );

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_ss();
        btn_ss = 1'b1; tick(1); btn_ss = 1'b0;
    endtask

    task automatic press_lap();
        btn_lap = 1'b1; tick(1); btn_lap = 1'b0;
    endtask

    task automatic press_clr();
        btn_clr = 1'b1; tick(1); btn_clr = 1'b0;
    endtask

    // scoreboard check
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        tick(2);
        check("rst_state", a_st, ST_IDLE);
        check("rst_time", a_time, 0);
        check("rst_running", a_run, 0);
        check("rst_hold", a_hold, 0);
        check("rst_laps", a_laps, 0);
        check("rst_ovf", a_ovf, 0);
        rst = 1'b0;
        tick(1);

        // start, 1000 ticks, stop
        press_ss();
        tick(999);
        press_ss();
        tick(1);
        check("stop_time", a_time, 1000);
        check("stop_running", a_run, 0);
        check("stop_state", a_st, ST_PAUSED);
        tick(10);
        check("paused_hold_time", a_time, 1000);

        // lap capture at 500, release after 200 clocks
        press_clr();
        press_ss();
        tick(500);
        press_lap();
        tick(1);
        check("lap_time", a_time, 500);
        check("lap_hold", a_hold, 1);
        check("lap_count1", a_laps, 1);
        check("lap_running", a_run, 1);
        tick(199);
        check("lap_frozen", a_time, 500);
        press_lap();
        tick(1);
        check("lap_release_time", a_time, 702);
        check("lap_release_hold", a_hold, 0);
        check("lap_release_count", a_laps, 1);
        check("lap_release_state", a_st, ST_RUN);

        // simultaneous edges while RUN: clear wins
        btn_ss = 1'b1; btn_lap = 1'b1; btn_clr = 1'b1;
        tick(1);
        btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        tick(1);
        check("simul_state", a_st, ST_IDLE);
        check("simul_time", a_time, 0);
        check("simul_running", a_run, 0);
        check("simul_hold", a_hold, 0);
        check("simul_laps", a_laps, 0);
        check("simul_ovf", a_ovf, 0);
        tick(5);
        check("simul_still_idle", a_time, 0);

        // saturation on the MAX_TICKS=100 instance
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(1);
        press_ss();
        tick(100);
        tick(3);
        check("sat_time", b_time, 100);
        check("sat_ovf", b_ovf, 1);
        check("sat_state", b_st, ST_PAUSED);
        check("sat_running", b_run, 0);
        check("nosat_ovf_a", a_ovf, 0);
        press_ss();
        tick(3);
        check("sat_start_ignored", b_st, ST_PAUSED);
        check("sat_time_held", b_time, 100);
        check("sat_ovf_sticky", b_ovf, 1);
        press_clr();
        tick(1);
        check("sat_clear_ovf", b_ovf, 0);
        check("sat_clear_state", b_st, ST_IDLE);
        check("sat_clear_time", b_time, 0);

        // buttons held through reset give no edge; lap_count saturates
        btn_ss = 1'b1; btn_lap = 1'b1;
        rst = 1'b1; tick(2); rst = 1'b0;
        tick(5);
        check("held_state", a_st, ST_IDLE);
        check("held_laps", a_laps, 0);
        check("held_time", a_time, 0);
        check("held_hold", a_hold, 0);
        btn_ss = 1'b0; btn_lap = 1'b0;
        tick(1);
        press_ss();
        tick(1);
        for (int i = 0; i < 16; i++) begin
            press_lap();
            tick(1);
            if (i == 0) check("laps_first", a_laps, 1);
            press_lap();
            tick(1);
        end
        tick(1);
        check("laps_sat", a_laps, 15);
        check("laps_sat_state", a_st, ST_RUN);
        check("laps_sat_hold", a_hold, 0);

        // reset during LAP
        press_lap();
        tick(2);
        check("pre_rst_hold", a_hold, 1);
        rst = 1'b1;
        tick(1);
        check("rst_lap_state", a_st, ST_IDLE);
        check("rst_lap_time", a_time, 0);
        check("rst_lap_hold", a_hold, 0);
        check("rst_lap_running", a_run, 0);
        check("rst_lap_laps", a_laps, 0);
        rst = 1'b0;
        tick(2);
        check("post_rst_state", a_st, ST_IDLE);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 SHALL have parameter MAX_TICKS, default 39'd359_999_999_999, the saturation count (59:59.999 in 10 ns ticks).
REQ-002 SHALL have parameter LAP_MAX, default 15, the lap counter saturation value.
REQ-003 SHALL have port clk, input, 1, the single clock (100 MHz; one tick = 10 ns).
REQ-004 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-005 SHALL have port btn_start_stop, input, 1, a debounced level, acted on at its rising edge.
REQ-006 SHALL have port btn_lap, input, 1, a debounced level, acted on at its rising edge.
REQ-007 SHALL have port btn_clear, input, 1, a debounced level, acted on at its rising edge.
REQ-008 SHALL have port time_out, output, 39, the displayed tick count fed to the time-to-BCD converter.
REQ-009 SHALL have port running, output, 1, set while the elapsed counter advances.
REQ-010 SHALL have port lap_hold, output, 1, set while time_out shows a frozen lap value.
REQ-011 SHALL have port lap_count, output, 4, the number of laps captured since clear.
REQ-012 SHALL have port overflow, output, 1, a sticky flag set when the counter saturated.

Function
REQ-013 A rising edge SHALL be detected when the input is sampled high at the current clk edge and was sampled low at the previous clk edge; each edge acts exactly once.
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, PAUSED and LAP.
REQ-015 On a start_stop edge, IDLE SHALL go to RUN, RUN to PAUSED, PAUSED to RUN, and LAP to PAUSED (lap_hold cleared).
REQ-016 On a lap edge, RUN SHALL capture the elapsed count into the lap register, increment lap_count (saturating at LAP_MAX), and go to LAP.
REQ-017 On a lap edge, LAP SHALL go to RUN, releasing the hold without capturing; in IDLE and PAUSED the lap edge SHALL be ignored.
REQ-018 A clear edge in any state SHALL go to IDLE and zero the elapsed counter, lap register, lap_count and overflow.
REQ-019 Simultaneous edges SHALL be resolved with priority clear > start_stop > lap; lower-priority edges in the same cycle are discarded.
REQ-020 The elapsed counter SHALL increment by 1 on every clk edge while the state is RUN or LAP, and hold otherwise.
REQ-021 The first increment after an IDLE/PAUSED->RUN transition SHALL occur on the clk edge following the transition edge.
REQ-022 When the counter equals MAX_TICKS while advancing, it SHALL hold at MAX_TICKS, set overflow, and go to PAUSED on that same edge.
REQ-023 From PAUSED with overflow set, a start_stop edge SHALL be ignored; only clear leaves that condition.
REQ-024 time_out SHALL be registered, equal to the lap register in LAP and to the elapsed counter otherwise, and SHALL reflect each state/count update one clk after it.
REQ-025 running SHALL equal (state==RUN or state==LAP), and lap_hold SHALL equal (state==LAP); both SHALL be registered.
REQ-026 All arithmetic SHALL be unsigned 39-bit, and the counter SHALL never wrap.

Reset
REQ-027 While rst is sampled high, the state SHALL be IDLE and the counter, lap register, time_out, running, lap_hold, lap_count and overflow SHALL all be 0.
REQ-028 Reset SHALL override all button edges in the same cycle, and reset mid-RUN or mid-LAP SHALL take effect on that clk edge.
REQ-029 The button history registers SHALL reset to 1, so a button held through reset produces no edge.

Structure
REQ-030 State encoding (2-bit), MAX_TICKS, tick width (39) and lap_count width SHALL reside in shared package stopwatch_pkg.
REQ-031 One sub-module, edge_detect (1-bit rising-edge detector with sync reset), SHALL be instantiated three times.
REQ-032 No division or BCD logic SHALL exist in this block; time_out connects directly to the existing converter.

Verification
REQ-033 The bench SHALL cover: reset, start edge, wait 1000 clk, stop edge -> time_out=1000 (±1 per REQ-021), running=0, state PAUSED.
REQ-034 The bench SHALL cover: RUN at count 500, lap edge -> time_out frozen at 500 while the counter advances; after 200 clk, lap edge -> time_out≈700+, lap_count=1.
REQ-035 The bench SHALL cover: start, lap, and clear edges asserted in the same cycle while RUN -> IDLE, all outputs 0.
REQ-036 The bench SHALL cover: MAX_TICKS overridden to 100, run -> time_out holds 100, overflow=1, PAUSED, and a further start edge is ignored.
REQ-037 The bench SHALL cover: btn_lap held high across a reset deassertion -> no lap captured, and 16 lap cycles -> lap_count stays 15.
REQ-038 The bench SHALL cover: rst pulsed during LAP -> next cycle IDLE, time_out=0, lap_hold=0.
